uart_word_rx: RTL and testbench
===============================

// Module: uart_word_rx
// PURPOSE
//  UART receiver that sits directly upstream of the input controller. Deserialises 8N1 frames
//  from rxd, packs every 4 bytes into one 32-bit word and pulses word_valid for one cycle.
//  Carries program headers, section data and runtime input data; the consumer has no backpressure.
// PARAMETERS
//  CLKS_PER_BIT  868  clock cycles per UART bit (100 MHz / 115200); must be >= 4
//  SYNC_STAGES   2    flip-flop stages on rxd before use; must be >= 2
// PORTS
//  clk         in   1   system clock, only clock in the block
//  rstn        in   1   asynchronous active-low reset
//  rxd         in   1   UART serial input, idle high, asynchronous to clk
//  word_valid  out  1   one-cycle pulse: word_data holds a complete new word
//  word_data   out  32  assembled word; first received byte in [7:0] (little-endian)
//  frame_err   out  1   one-cycle pulse: stop bit sampled low, byte discarded
// BEHAVIOUR
//  Reset: rstn low asynchronously clears all state.
//  - word_valid=0, frame_err=0, word_data=0.
//  - Sync chain =1, FSM=IDLE, all counters =0, partial word discarded.
//  Reset mid-frame: the next word is built only from frames whose start edge follows rstn release.
//  Sync: rxd_s = last stage of SYNC_STAGES flops. All decisions use rxd_s only.
//  Counters:
//  - clk_cnt: $clog2(CLKS_PER_BIT) bits.
//  - bit_cnt: 3 bits.
//  - byte_cnt: 2 bits; wraps 3 -> 0 on a completed word.
//  FSM:
//  - IDLE: rxd_s==0 -> START, clk_cnt=0.
//  - START: at clk_cnt==CLKS_PER_BIT/2-1, resample.
//    - rxd_s==1: false start (glitch) -> IDLE, no output.
//    - rxd_s==0: -> DATA, clk_cnt=0, bit_cnt=0.
//  - DATA: sample at clk_cnt==CLKS_PER_BIT-1, i.e. the centre of each bit.
//    - Shift LSB-first into shift_reg[7:0]; clk_cnt=0.
//    - Leave after bit_cnt==7 -> STOP.
//  - STOP: sample at clk_cnt==CLKS_PER_BIT-1.
//    - rxd_s==1: byte accepted; write shift_reg into word lane byte_cnt; byte_cnt++; -> IDLE.
//      If byte_cnt was 3: next cycle word_data = assembled word, word_valid=1 for exactly 1 cycle.
//    - rxd_s==0: frame_err=1 next cycle for 1 cycle; byte dropped; byte_cnt and partial word
//      unchanged; -> BREAK.
//  - BREAK: wait for rxd_s==1 -> IDLE. Only one frame_err per break, however long rxd stays low.
//  Latency and timing:
//  - word_valid rises 1 cycle after the stop-bit centre sample of the 4th byte.
//  - Returning to IDLE at stop-bit centre tolerates zero idle time between frames and
//    +/-~4% baud mismatch.
//  word_data: stable between pulses; updated only together with word_valid.
//  word_valid and frame_err: never high in the same cycle.
//  No backpressure: the consumer must accept word_valid in the cycle it is high.
//  Partial-word progress (byte_cnt) is not exposed; only reset clears it.
// TESTING (bench uses CLKS_PER_BIT=8 unless stated)
//  1. Send bytes 78,56,34,12 with 2-bit idle gaps.
//     -> exactly one word_valid pulse, word_data=32'h12345678, frame_err never high.
//  2. Send 8 bytes back-to-back (stop bit followed immediately by next start) 01..08.
//     -> two pulses: 32'h04030201 then 32'h08070605.
//  3. rxd low for 2 cycles only (glitch), then send AA,BB,CC,DD.
//     -> no extra byte; word_data=32'hDDCCBBAA.
//  4. Send 11, then a frame with stop bit low, then hold rxd low 50 bit-times, release,
//     then send 22,33,44.
//     -> exactly one frame_err pulse; word_data=32'h44332211.
//  5. Send 2 bytes, assert rstn low mid-3rd byte for 3 cycles, then send 01,02,03,04.
//     -> outputs 0 during reset; single word 32'h04030201.
//  6. CLKS_PER_BIT=868, baud skewed +3%, send DE,AD,BE,EF.
//     -> word_data=32'hEFBEADDE, no frame_err.

Source files
------------

// File: rtl/uart_word_rx_if.sv
// Serial input and word-output bundle of the UART word receiver.
// master = receiver side, slave = driver of rxd / consumer of words.
interface uart_word_rx_if;
   logic        rxd;
   logic        word_valid;
   logic [31:0] word_data;
   logic        frame_err;

   modport master (input rxd, output word_valid, output word_data, output frame_err);
   modport slave  (output rxd, input word_valid, input word_data, input frame_err);
endinterface

// File: rtl/uart_word_rx.sv
// 8N1 UART receiver packing 4 bytes (first byte in [7:0]) into a word; word_valid pulses 1 cycle
// after the 4th stop-bit centre sample. No backpressure: the consumer must take word_valid when high.
module uart_word_rx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int SYNC_STAGES  = 2
) (
   input  logic           clk,
   input  logic           rstn,
   uart_word_rx_if.master bus
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

   state_t                 state_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0]          clk_cnt_q;
   logic [2:0]             bit_cnt_q;
   logic [1:0]             byte_cnt_q;
   logic [7:0]             shift_q;
   logic [31:0]            part_q;
   logic [31:0]            part_d;
   logic [31:0]            word_data_q;
   logic                   word_valid_q;
   logic                   frame_err_q;
   logic                   rxd_s;

   assign rxd_s = sync_q[SYNC_STAGES-1];

   // Completed byte dropped into the lane selected by the current byte count.
   always_comb begin
      part_d = part_q;
      part_d[{byte_cnt_q, 3'b000} +: 8] = shift_q;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= S_IDLE;
         sync_q       <= '1;
         clk_cnt_q    <= '0;
         bit_cnt_q    <= '0;
         byte_cnt_q   <= '0;
         shift_q      <= '0;
         part_q       <= '0;
         word_data_q  <= '0;
         word_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         sync_q       <= {sync_q[SYNC_STAGES-2:0], bus.rxd};
         word_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               clk_cnt_q <= '0;
               if (!rxd_s) state_q <= S_START;
            end
            S_START: begin
               if (clk_cnt_q == HALF_M1) begin
                  clk_cnt_q <= '0;
                  bit_cnt_q <= '0;
                  state_q   <= rxd_s ? S_IDLE : S_DATA;
               end else begin
                  clk_cnt_q <= clk_cnt_q + 1'b1;
               end
            end
            S_DATA: begin
               if (clk_cnt_q == FULL_M1) begin
                  clk_cnt_q <= '0;
                  shift_q   <= {rxd_s, shift_q[7:1]};
                  bit_cnt_q <= bit_cnt_q + 1'b1;
                  if (bit_cnt_q == 3'd7) state_q <= S_STOP;
               end else begin
                  clk_cnt_q <= clk_cnt_q + 1'b1;
               end
            end
            S_STOP: begin
               if (clk_cnt_q == FULL_M1) begin
                  clk_cnt_q <= '0;
                  if (rxd_s) begin
                     part_q     <= part_d;
                     byte_cnt_q <= byte_cnt_q + 1'b1;
                     if (byte_cnt_q == 2'd3) begin
                        word_data_q  <= part_d;
                        word_valid_q <= 1'b1;
                     end
                     state_q <= S_IDLE;
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= S_BREAK;
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_q + 1'b1;
               end
            end
            S_BREAK: begin
               // A single error per break: wait for the line to return high.
               if (rxd_s) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.word_valid = word_valid_q;
   assign bus.word_data  = word_data_q;
   assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_uart_word_rx.sv
// Directed bench: a fast receiver (8 clocks/bit) for functional cases and a 868 clocks/bit one
// driven with a 3% faster baud.
module tb_uart_word_rx;
   localparam int FAST = 8;
   localparam int SLOW = 868;
   localparam int SKEW = 842;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   tests = 0;
   int   fails = 0;

   uart_word_rx_if bus_f ();
   uart_word_rx_if bus_s ();

   uart_word_rx #(.CLKS_PER_BIT(FAST), .SYNC_STAGES(2)) dut_f (.clk(clk), .rstn(rstn), .bus(bus_f));
   uart_word_rx #(.CLKS_PER_BIT(SLOW), .SYNC_STAGES(2)) dut_s (.clk(clk), .rstn(rstn), .bus(bus_s));

   always #5 clk = ~clk;

   logic [31:0] words_f[$];
   logic [31:0] words_s[$];
   int ferr_f = 0, ferr_s = 0, ovl_f = 0, ovl_s = 0;

   always @(negedge clk) begin
      if (bus_f.word_valid === 1'b1) words_f.push_back(bus_f.word_data);
      if (bus_s.word_valid === 1'b1) words_s.push_back(bus_s.word_data);
      if (bus_f.frame_err === 1'b1) ferr_f++;
      if (bus_s.frame_err === 1'b1) ferr_s++;
      if (bus_f.word_valid === 1'b1 && bus_f.frame_err === 1'b1) ovl_f++;
      if (bus_s.word_valid === 1'b1 && bus_s.frame_err === 1'b1) ovl_s++;
   end

   task automatic clear_mon();
      words_f.delete();
      words_s.delete();
      ferr_f = 0; ferr_s = 0; ovl_f = 0; ovl_s = 0;
   endtask

   task automatic drive(input bit sel, input logic v, input int n);
      if (sel) bus_s.rxd = v;
      else     bus_f.rxd = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input bit sel, input logic [7:0] b, input logic stop,
                             input int bclk, input int gap);
      drive(sel, 1'b0, bclk);
      for (int i = 0; i < 8; i++) drive(sel, b[i], bclk);
      drive(sel, stop, bclk);
      if (gap > 0) drive(sel, 1'b1, gap * bclk);
   endtask

   function automatic logic [31:0] word_at(input int idx, input bit sel);
      if (sel) return (words_s.size() > idx) ? words_s[idx] : 32'hxxxx_xxxx;
      return (words_f.size() > idx) ? words_f[idx] : 32'hxxxx_xxxx;
   endfunction

   task automatic test_reset();
      @(negedge clk);
      tests++;
      if (bus_f.word_valid !== 1'b0) begin fails++; $display("FAIL reset_valid_f got %b exp 0", bus_f.word_valid); end
      tests++;
      if (bus_f.frame_err !== 1'b0) begin fails++; $display("FAIL reset_ferr_f got %b exp 0", bus_f.frame_err); end
      tests++;
      if (bus_f.word_data !== 32'h0) begin fails++; $display("FAIL reset_data_f got %h exp 0", bus_f.word_data); end
      tests++;
      if (bus_s.word_valid !== 1'b0 || bus_s.frame_err !== 1'b0 || bus_s.word_data !== 32'h0) begin
         fails++; $display("FAIL reset_slow got v=%b e=%b d=%h exp all 0", bus_s.word_valid, bus_s.frame_err, bus_s.word_data);
      end
   endtask

   task automatic test_gapped();
      logic [7:0] b[4] = '{8'h78, 8'h56, 8'h34, 8'h12};
      clear_mon();
      foreach (b[i]) send_frame(1'b0, b[i], 1'b1, FAST, 2);
      repeat (16) @(negedge clk);
      tests++;
      if (words_f.size() != 1) begin fails++; $display("FAIL gapped_count got %0d exp 1", words_f.size()); end
      tests++;
      if (word_at(0, 1'b0) !== 32'h12345678) begin fails++; $display("FAIL gapped_word got %h exp 12345678", word_at(0, 1'b0)); end
      tests++;
      if (ferr_f != 0) begin fails++; $display("FAIL gapped_ferr got %0d exp 0", ferr_f); end
   endtask

   task automatic test_back_to_back();
      clear_mon();
      for (int i = 1; i <= 8; i++) send_frame(1'b0, 8'(i), 1'b1, FAST, 0);
      drive(1'b0, 1'b1, 2 * FAST);
      tests++;
      if (words_f.size() != 2) begin fails++; $display("FAIL b2b_count got %0d exp 2", words_f.size()); end
      tests++;
      if (word_at(0, 1'b0) !== 32'h04030201) begin fails++; $display("FAIL b2b_word0 got %h exp 04030201", word_at(0, 1'b0)); end
      tests++;
      if (word_at(1, 1'b0) !== 32'h08070605) begin fails++; $display("FAIL b2b_word1 got %h exp 08070605", word_at(1, 1'b0)); end
      tests++;
      if (bus_f.word_data !== 32'h08070605) begin fails++; $display("FAIL b2b_hold got %h exp 08070605", bus_f.word_data); end
   endtask

   task automatic test_glitch();
      logic [7:0] b[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      clear_mon();
      drive(1'b0, 1'b0, 2);
      drive(1'b0, 1'b1, 2 * FAST);
      foreach (b[i]) send_frame(1'b0, b[i], 1'b1, FAST, 1);
      repeat (16) @(negedge clk);
      tests++;
      if (words_f.size() != 1) begin fails++; $display("FAIL glitch_count got %0d exp 1", words_f.size()); end
      tests++;
      if (word_at(0, 1'b0) !== 32'hDDCCBBAA) begin fails++; $display("FAIL glitch_word got %h exp DDCCBBAA", word_at(0, 1'b0)); end
   endtask

   task automatic test_break();
      clear_mon();
      send_frame(1'b0, 8'h11, 1'b1, FAST, 1);
      send_frame(1'b0, 8'h5A, 1'b0, FAST, 0);
      drive(1'b0, 1'b0, 50 * FAST);
      drive(1'b0, 1'b1, 2 * FAST);
      send_frame(1'b0, 8'h22, 1'b1, FAST, 1);
      send_frame(1'b0, 8'h33, 1'b1, FAST, 1);
      send_frame(1'b0, 8'h44, 1'b1, FAST, 1);
      repeat (16) @(negedge clk);
      tests++;
      if (ferr_f != 1) begin fails++; $display("FAIL break_ferr got %0d cycles exp 1", ferr_f); end
      tests++;
      if (words_f.size() != 1) begin fails++; $display("FAIL break_count got %0d exp 1", words_f.size()); end
      tests++;
      if (word_at(0, 1'b0) !== 32'h44332211) begin fails++; $display("FAIL break_word got %h exp 44332211", word_at(0, 1'b0)); end
      tests++;
      if (ovl_f != 0 || ovl_s != 0) begin fails++; $display("FAIL overlap got %0d/%0d exp 0", ovl_f, ovl_s); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] b[4] = '{8'h01, 8'h02, 8'h03, 8'h04};
      clear_mon();
      send_frame(1'b0, 8'hA1, 1'b1, FAST, 1);
      send_frame(1'b0, 8'hB2, 1'b1, FAST, 1);
      drive(1'b0, 1'b0, FAST);
      drive(1'b0, 1'b1, 3 * FAST);
      rstn = 1'b0;
      @(negedge clk);
      tests++;
      if (bus_f.word_valid !== 1'b0 || bus_f.frame_err !== 1'b0 || bus_f.word_data !== 32'h0) begin
         fails++; $display("FAIL midrst_outputs got v=%b e=%b d=%h exp all 0", bus_f.word_valid, bus_f.frame_err, bus_f.word_data);
      end
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      drive(1'b0, 1'b1, 6 * FAST);
      foreach (b[i]) send_frame(1'b0, b[i], 1'b1, FAST, 1);
      repeat (16) @(negedge clk);
      tests++;
      if (words_f.size() != 1) begin fails++; $display("FAIL midrst_count got %0d exp 1", words_f.size()); end
      tests++;
      if (word_at(0, 1'b0) !== 32'h04030201) begin fails++; $display("FAIL midrst_word got %h exp 04030201", word_at(0, 1'b0)); end
   endtask

   task automatic test_skew();
      logic [7:0] b[4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      clear_mon();
      foreach (b[i]) send_frame(1'b1, b[i], 1'b1, SKEW, 1);
      repeat (1000) @(negedge clk);
      tests++;
      if (words_s.size() != 1) begin fails++; $display("FAIL skew_count got %0d exp 1", words_s.size()); end
      tests++;
      if (word_at(0, 1'b1) !== 32'hEFBEADDE) begin fails++; $display("FAIL skew_word got %h exp EFBEADDE", word_at(0, 1'b1)); end
      tests++;
      if (ferr_s != 0) begin fails++; $display("FAIL skew_ferr got %0d exp 0", ferr_s); end
   endtask

   initial begin
      bus_f.rxd = 1'b1;
      bus_s.rxd = 1'b1;
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      test_reset();
      rstn = 1'b1;
      repeat (4) @(negedge clk);
      test_gapped();
      test_back_to_back();
      test_glitch();
      test_break();
      test_reset_mid();
      test_skew();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
